// File: rtl/sw_pio_servicer.sv
// sw_pio_servicer
//   Services a slide-switch PIO over a simple Avalon-MM master port. On a
//   level interrupt it reads the edge-capture register, clears it, reads the
//   switch levels and presents the result as a valid/ready event. A software
//   irq mask can be requested at any time and is written to the PIO the next
//   time the FSM is idle.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   avm_address         PIO register address (0 data, 2 irq mask, 3 edge capture)
//   avm_chipselect      PIO access strobe
//   avm_write_n         active-low write strobe
//   avm_writedata       PIO write data
//   avm_readdata        PIO registered read data (valid the cycle after the address)
//   pio_irq             level interrupt from the PIO
//   cfg_mask            requested irq mask
//   cfg_mask_load       one-cycle pulse requesting a cfg_mask write
//   evt_valid           switch event available
//   evt_ready           consumer accepts event
//   evt_changed         masked edge-capture bits of the event
//   evt_sw              switch levels read after the capture clear
//   busy                high in every state except IDLE

module sw_pio_servicer (
  input  logic        clk,
  input  logic        reset_n,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        pio_irq,
  input  logic [8:0]  cfg_mask,
  input  logic        cfg_mask_load,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [8:0]  evt_changed,
  output logic [8:0]  evt_sw,
  output logic        busy
);

  localparam int DATA_W = 9;

  localparam logic [2:0]  ADDR_DATA = 3'd0;
  localparam logic [2:0]  ADDR_MASK = 3'd2;
  localparam logic [2:0]  ADDR_CAP  = 3'd3;
  localparam logic [31:0] CAP_CLEAR = 32'h0000_01FF;

  typedef enum logic [3:0] {
    INIT_MASK,
    IDLE,
    RD_CAP,
    WT_CAP,
    CLR_CAP,
    RD_DAT,
    WT_DAT,
    PRESENT,
    WR_MASK
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] mask_lat;
  logic              pending_q;
  logic [DATA_W-1:0] cap_q;

  logic              cs_c;
  logic              wn_c;
  logic [2:0]        addr_c;
  logic [31:0]       wd_c;

  // Only the switch-width bits of the PIO read data carry information.
  logic unused_rd_hi;
  assign unused_rd_hi = ^avm_readdata[31:DATA_W];

  function automatic logic [31:0] zext(input logic [DATA_W-1:0] v);
    return {{(32-DATA_W){1'b0}}, v};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT_MASK;
    else          state <= state_nxt;
  end

  // Mask request bookkeeping: a load in any state overwrites the latched
  // value (last wins). A load coinciding with WR_MASK keeps the flag set so
  // the newer value is written on the next pass through IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      mask_lat  <= '0;
      mask_q    <= '0;
    end else begin
      if (cfg_mask_load) begin
        pending_q <= 1'b1;
        mask_lat  <= cfg_mask;
      end else if (state == WR_MASK) begin
        pending_q <= 1'b0;
      end
      if (state == WR_MASK) mask_q <= mask_lat;
    end
  end

  // Read data is registered in the PIO, so it is taken on the edge that
  // leaves the wait state following each read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q       <= '0;
      evt_changed <= '0;
      evt_sw      <= '0;
    end else begin
      if (state == WT_CAP) cap_q <= avm_readdata[DATA_W-1:0] & mask_q;
      if (state == WT_DAT) begin
        evt_sw      <= avm_readdata[DATA_W-1:0];
        evt_changed <= cap_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cs_c      = 1'b0;
    wn_c      = 1'b1;
    addr_c    = 3'd0;
    wd_c      = 32'd0;
    case (state)
      INIT_MASK: begin
        cs_c      = 1'b1;
        wn_c      = 1'b0;
        addr_c    = ADDR_MASK;
        wd_c      = zext(mask_q);
        state_nxt = IDLE;
      end
      IDLE: begin
        if (pending_q)    state_nxt = WR_MASK;
        else if (pio_irq) state_nxt = RD_CAP;
      end
      RD_CAP: begin
        cs_c      = 1'b1;
        addr_c    = ADDR_CAP;
        state_nxt = WT_CAP;
      end
      WT_CAP: state_nxt = CLR_CAP;
      CLR_CAP: begin
        // Edges landing between the capture sample and this clear are
        // dropped; a masked-off or spurious irq ends here with no event.
        cs_c      = 1'b1;
        wn_c      = 1'b0;
        addr_c    = ADDR_CAP;
        wd_c      = CAP_CLEAR;
        state_nxt = (cap_q == '0) ? IDLE : RD_DAT;
      end
      RD_DAT: begin
        cs_c      = 1'b1;
        addr_c    = ADDR_DATA;
        state_nxt = WT_DAT;
      end
      WT_DAT: state_nxt = PRESENT;
      PRESENT: begin
        if (evt_ready) state_nxt = IDLE;
      end
      WR_MASK: begin
        cs_c      = 1'b1;
        wn_c      = 1'b0;
        addr_c    = ADDR_MASK;
        wd_c      = zext(mask_lat);
        state_nxt = IDLE;
      end
      default: state_nxt = INIT_MASK;
    endcase
  end

  // While reset is held the FSM sits in INIT_MASK, whose write must not
  // reach the bus until reset is released.
  assign avm_chipselect = reset_n & cs_c;
  assign avm_write_n    = reset_n ? wn_c   : 1'b1;
  assign avm_address    = reset_n ? addr_c : 3'd0;
  assign avm_writedata  = reset_n ? wd_c   : 32'd0;

  assign evt_valid = (state == PRESENT);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sw_pio_servicer.sv
module tb_sw_pio_servicer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        pio_irq;
  logic [8:0]  cfg_mask;
  logic        cfg_mask_load;
  logic        evt_valid;
  logic        evt_ready;
  logic [8:0]  evt_changed;
  logic [8:0]  evt_sw;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Switch PIO model
  logic [8:0]  sw        = '0;
  logic [8:0]  sw_q      = '0;
  logic [8:0]  cap_m     = '0;
  logic [8:0]  irqm      = '0;
  logic [31:0] rdata     = '0;
  logic        irq_force = 1'b0;
  int          wr_cnt    = 0;
  logic [8:0]  clr_bits;

  sw_pio_servicer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .pio_irq        (pio_irq),
    .cfg_mask       (cfg_mask),
    .cfg_mask_load  (cfg_mask_load),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_changed    (evt_changed),
    .evt_sw         (evt_sw),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign clr_bits     = (avm_chipselect && !avm_write_n && avm_address == 3'd3) ? avm_writedata[8:0] : 9'd0;
  assign pio_irq      = irq_force | (|(cap_m & irqm));
  assign avm_readdata = rdata;

  always @(posedge clk) begin
    sw_q  <= sw;
    cap_m <= (cap_m & ~clr_bits) | (sw ^ sw_q);
    if (avm_chipselect && !avm_write_n) begin
      wr_cnt <= wr_cnt + 1;
      if (avm_address == 3'd2) irqm <= avm_writedata[8:0];
    end
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        3'd0:    rdata <= {23'd0, sw};
        3'd2:    rdata <= {23'd0, irqm};
        3'd3:    rdata <= {23'd0, cap_m};
        default: rdata <= 32'd0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic cs, input logic wn,
                     input logic [2:0] addr, input logic [31:0] wd);
    check({tag, ".cs"},   {31'd0, avm_chipselect}, {31'd0, cs});
    check({tag, ".wn"},   {31'd0, avm_write_n},    {31'd0, wn});
    check({tag, ".addr"}, {29'd0, avm_address},    {29'd0, addr});
    check({tag, ".wd"},   avm_writedata,           wd);
  endtask

  task automatic load_mask(input logic [8:0] m);
    cfg_mask      = m;
    cfg_mask_load = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
    check("ld.idle_busy", {31'd0, busy}, 32'd0);
    tick();
    bus("ld.wr_mask", 1'b1, 1'b0, 3'd2, {23'd0, m});
    tick();
    check("ld.back_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n       = 1'b0;
    cfg_mask      = '0;
    cfg_mask_load = 1'b0;
    evt_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst.busy", {31'd0, busy}, 32'd1);
    check("rst.valid", {31'd0, evt_valid}, 32'd0);
    check("rst.changed", {23'd0, evt_changed}, 32'd0);
    check("rst.sw", {23'd0, evt_sw}, 32'd0);
    bus("rst.bus", 1'b0, 1'b1, 3'd0, 32'd0);

    // Reset release: one mask write of 0, then IDLE
    reset_n = 1'b1;
    #1;
    bus("init.wr", 1'b1, 1'b0, 3'd2, 32'd0);
    tick();
    check("init.idle_busy", {31'd0, busy}, 32'd0);
    bus("init.idle_bus", 1'b0, 1'b1, 3'd0, 32'd0);
    check("init.wr_cnt", wr_cnt, 1);

    // Mask load 0x1FF in IDLE
    load_mask(9'h1FF);
    tick();
    bus("ld.no_rewrite", 1'b0, 1'b1, 3'd0, 32'd0);
    check("ld.wr_cnt", wr_cnt, 2);

    // Switch 3 toggles: full service sequence
    sw = 9'h008;
    tick();
    check("e1.irq", {31'd0, pio_irq}, 32'd1);
    check("e1.busy", {31'd0, busy}, 32'd0);
    tick();
    bus("e1.rd_cap", 1'b1, 1'b1, 3'd3, 32'd0);
    tick();
    bus("e1.wt_cap", 1'b0, 1'b1, 3'd0, 32'd0);
    tick();
    bus("e1.clr_cap", 1'b1, 1'b0, 3'd3, 32'h1FF);
    tick();
    bus("e1.rd_dat", 1'b1, 1'b1, 3'd0, 32'd0);
    tick();
    check("e1.wt_dat_valid", {31'd0, evt_valid}, 32'd0);
    tick();
    check("e1.valid", {31'd0, evt_valid}, 32'd1);
    check("e1.changed", {23'd0, evt_changed}, 32'h008);
    check("e1.sw", {23'd0, evt_sw}, 32'h008);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("e1.done_valid", {31'd0, evt_valid}, 32'd0);
    check("e1.done_busy", {31'd0, busy}, 32'd0);

    // Masked-off capture with forced irq: clear, no event
    load_mask(9'h001);
    sw = 9'h00E;
    tick();
    check("sp.irq_masked", {31'd0, pio_irq}, 32'd0);
    check("sp.busy", {31'd0, busy}, 32'd0);
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    bus("sp.rd_cap", 1'b1, 1'b1, 3'd3, 32'd0);
    tick();
    tick();
    bus("sp.clr_cap", 1'b1, 1'b0, 3'd3, 32'h1FF);
    tick();
    check("sp.idle_busy", {31'd0, busy}, 32'd0);
    check("sp.no_valid", {31'd0, evt_valid}, 32'd0);
    tick();
    check("sp.still_idle", {31'd0, busy}, 32'd0);
    check("sp.still_no_valid", {31'd0, evt_valid}, 32'd0);

    // Backpressure: event held stable while switch 5 toggles again
    load_mask(9'h1FF);
    sw = 9'h02E;
    ticks(7);
    check("bp.valid", {31'd0, evt_valid}, 32'd1);
    check("bp.changed", {23'd0, evt_changed}, 32'h020);
    check("bp.sw", {23'd0, evt_sw}, 32'h02E);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) sw = 9'h00E;
      tick();
      check("bp.hold_valid", {31'd0, evt_valid}, 32'd1);
      check("bp.hold_changed", {23'd0, evt_changed}, 32'h020);
      check("bp.hold_sw", {23'd0, evt_sw}, 32'h02E);
    end
    evt_ready = 1'b1;
    tick();
    check("bp.hs_valid", {31'd0, evt_valid}, 32'd0);
    check("bp.hs_busy", {31'd0, busy}, 32'd0);
    ticks(5);
    check("bp2.wt_dat_valid", {31'd0, evt_valid}, 32'd0);
    tick();
    check("bp2.valid", {31'd0, evt_valid}, 32'd1);
    check("bp2.changed", {23'd0, evt_changed}, 32'h020);
    check("bp2.sw", {23'd0, evt_sw}, 32'h00E);
    tick();
    evt_ready = 1'b0;
    check("bp2.done_valid", {31'd0, evt_valid}, 32'd0);

    // Mask load during WT_CAP with irq pending at IDLE: mask first
    sw = 9'h01E;
    tick();
    tick();
    bus("pr.rd_cap", 1'b1, 1'b1, 3'd3, 32'd0);
    tick();
    cfg_mask      = 9'h0F0;
    cfg_mask_load = 1'b1;
    irq_force     = 1'b1;
    tick();
    cfg_mask_load = 1'b0;
    bus("pr.clr_cap", 1'b1, 1'b0, 3'd3, 32'h1FF);
    ticks(3);
    check("pr.valid", {31'd0, evt_valid}, 32'd1);
    check("pr.changed", {23'd0, evt_changed}, 32'h010);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("pr.idle_busy", {31'd0, busy}, 32'd0);
    tick();
    bus("pr.wr_mask_first", 1'b1, 1'b0, 3'd2, 32'h0F0);
    tick();
    check("pr.idle2_busy", {31'd0, busy}, 32'd0);
    tick();
    bus("pr.rd_cap_after", 1'b1, 1'b1, 3'd3, 32'd0);
    irq_force = 1'b0;
    ticks(3);
    check("pr.end_busy", {31'd0, busy}, 32'd0);
    check("pr.end_valid", {31'd0, evt_valid}, 32'd0);

    // Reset while an event is held
    sw = 9'h09E;
    ticks(7);
    check("mr.valid", {31'd0, evt_valid}, 32'd1);
    check("mr.changed", {23'd0, evt_changed}, 32'h080);
    reset_n = 1'b0;
    #1;
    check("mr.rst_valid", {31'd0, evt_valid}, 32'd0);
    check("mr.rst_busy", {31'd0, busy}, 32'd1);
    check("mr.rst_changed", {23'd0, evt_changed}, 32'd0);
    check("mr.rst_sw", {23'd0, evt_sw}, 32'd0);
    bus("mr.rst_bus", 1'b0, 1'b1, 3'd0, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    bus("mr.init_wr", 1'b1, 1'b0, 3'd2, 32'd0);
    tick();
    check("mr.idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_pio_servicer.md
SW_PIO_SERVICER -- requirements
Module: sw_pio_servicer

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port avm_address, output, 3, switch-PIO register address (0 data, 2 irq mask, 3 edge capture).
REQ-004 SHALL have port avm_chipselect, output, 1, PIO access strobe.
REQ-005 SHALL have port avm_write_n, output, 1, active-low write strobe.
REQ-006 SHALL have port avm_writedata, output, 32, PIO write data.
REQ-007 SHALL have port avm_readdata, input, 32, PIO registered read data; valid the cycle after the address is driven.
REQ-008 SHALL have port pio_irq, input, 1, level interrupt from the switch PIO.
REQ-009 SHALL have port cfg_mask, input, 9, requested irq mask.
REQ-010 SHALL have port cfg_mask_load, input, 1, one-cycle pulse requesting a cfg_mask write.
REQ-011 SHALL have port evt_valid, output, 1, switch event available.
REQ-012 SHALL have port evt_ready, input, 1, consumer accepts event.
REQ-013 SHALL have port evt_changed, output, 9, edge-capture bits of the event, already masked.
REQ-014 SHALL have port evt_sw, output, 9, switch levels read after the clear.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL use states INIT_MASK, IDLE, RD_CAP, WT_CAP, CLR_CAP, RD_DAT, WT_DAT, PRESENT, WR_MASK.
REQ-017 SHALL hold a 9-bit mask register, reset 0x000; it is written only by accepted cfg_mask_load requests.
REQ-018 INIT_MASK SHALL write the mask register to address 2 for one cycle (chipselect=1, write_n=0), then go to IDLE.
REQ-019 A bus write SHALL last exactly one cycle; a bus read SHALL drive chipselect=1, write_n=1 and the address for one cycle, with avm_readdata sampled on the next edge.
REQ-020 Outside access cycles, outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-021 cfg_mask_load SHALL set a pending flag and latch cfg_mask in any state; a later pulse before service SHALL overwrite the latched value (last wins).
REQ-022 IDLE priority SHALL be: pending mask -> WR_MASK; else pio_irq=1 -> RD_CAP; else stay.
REQ-023 WR_MASK SHALL write the latched mask to address 2 for one cycle, clear the pending flag, and go to IDLE.
REQ-024 RD_CAP/WT_CAP SHALL read address 3 and capture cap = readdata[8:0] & mask.
REQ-025 CLR_CAP SHALL write 0x0000_01FF to address 3, which clears all capture bits.
REQ-026 Edges arriving between the RD_CAP sample and the CLR_CAP write SHALL be lost; this one-cycle window is the specified behaviour.
REQ-027 If cap==0 (spurious or masked-off interrupt), the FSM SHALL go from CLR_CAP to IDLE without producing an event.
REQ-028 RD_DAT/WT_DAT SHALL read address 0 into evt_sw[8:0] and load evt_changed=cap.
REQ-029 PRESENT SHALL hold evt_valid=1 with stable evt_changed and evt_sw until evt_valid&&evt_ready; it then goes to IDLE the following cycle.
REQ-030 pio_irq assertions during PRESENT SHALL be serviced only after the handshake; the level interrupt persists, so no edge is lost.
REQ-031 evt_ready SHALL be ignored when evt_valid=0.
REQ-032 Minimum irq-to-evt_valid latency from IDLE SHALL be 6 cycles (RD_CAP, WT_CAP, CLR_CAP, RD_DAT, WT_DAT, PRESENT).

Reset
REQ-033 On reset_n=0 the FSM SHALL enter INIT_MASK; mask=0, pending=0, evt_valid=0, evt_changed=0, evt_sw=0, busy=1, and bus outputs per REQ-020.
REQ-034 Reset mid-transaction SHALL abort it immediately, and any held event SHALL be discarded.

Verification
REQ-035 Reset release -> one write of 0x000 to address 2, then IDLE with busy=0.
REQ-036 cfg_mask=0x1FF load in IDLE -> address-2 write of 0x1FF two cycles later; pending clears.
REQ-037 mask=0x1FF, switch 3 toggles to 1 -> reads of address 3 and 0, write of 0x1FF to address 3, evt_changed=0x008, evt_sw=0x008, 6 cycles after irq.
REQ-038 mask=0x001, capture=0x006 with irq forced -> clear write issued, no evt_valid, return to IDLE.
REQ-039 evt_ready held 0 for 20 cycles while switch 5 toggles -> event stable; after the handshake a second event arrives with evt_changed=0x020.
REQ-040 cfg_mask_load=0x0F0 pulsed during WT_CAP, and pio_irq=1 at return to IDLE -> WR_MASK is serviced before RD_CAP.
